// File: rtl/jts16_snd_mixseq.sv
// Time-multiplexed N-channel audio mixer: one multiply-accumulate step per
// enabled clock, 4.4 fixed-point gains, saturating output and held peak flag.
//
// state | meaning
// IDLE  | waiting for a sample strobe; inputs snapshotted on the strobe
// ACC   | accumulating one channel per cen cycle
// SAT   | shift, saturate, publish mixed/valid, update peak hold
module jts16_snd_mixseq #(
  parameter int CH        = 4,
  parameter int W         = 16,
  parameter int WO        = 16,
  parameter int PEAK_HOLD = 3
) (
  input  logic             rst_n,
  input  logic             clk,
  input  logic             cen,
  input  logic             sample,
  input  logic [CH*W-1:0]  ch_flat,
  input  logic [CH*8-1:0]  gain_flat,
  output logic [WO-1:0]    mixed,
  output logic             valid,
  output logic             busy,
  output logic             peak,
  output logic             overrun
);

  localparam int IW = $clog2(CH);
  localparam int PW = W + 9;
  localparam int AW = PW + IW;
  localparam logic [IW-1:0] LAST = IW'(CH - 1);

  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

  state_t                state, state_nxt;
  logic [CH*W-1:0]       ch_q;
  logic [CH*8-1:0]       gain_q;
  logic [IW-1:0]         idx;
  logic signed [AW-1:0]  acc;
  logic [7:0]            cnt, cnt_nxt;

  logic signed [W-1:0]   ch_sel;
  logic [7:0]            gain_sel;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  acc_add;
  logic signed [AW-1:0]  r;
  logic                  fits;
  logic [WO-1:0]         sat_val;

  assign ch_sel   = ch_q[idx*W +: W];
  assign gain_sel = gain_q[idx*8 +: 8];
  // gain is unsigned, so a zero MSB keeps the product's sign from the sample
  assign prod     = PW'(ch_sel) * PW'($signed({1'b0, gain_sel}));
  assign acc_add  = acc + AW'(prod);

  // r fits in WO bits when everything above bit WO-2 is a copy of the sign
  assign r       = acc >>> 4;
  assign fits    = (&r[AW-1:WO-1]) | ~(|r[AW-1:WO-1]);
  assign sat_val = fits     ? r[WO-1:0] :
                   r[AW-1]  ? {1'b1, {(WO-1){1'b0}}} :
                              {1'b0, {(WO-1){1'b1}}};
  assign cnt_nxt = !fits        ? 8'(PEAK_HOLD) :
                   (cnt != 8'd0) ? cnt - 8'd1    : cnt;

  assign busy = (state != IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample) state_nxt = ACC;
      ACC:     if (cen && idx == LAST) state_nxt = SAT;
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // snapshot, accumulate, publish result and track peak hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q    <= '0;
      gain_q  <= '0;
      idx     <= '0;
      acc     <= '0;
      cnt     <= '0;
      mixed   <= '0;
      valid   <= 1'b0;
      peak    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (sample && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (sample) begin
          ch_q   <= ch_flat;
          gain_q <= gain_flat;
          acc    <= '0;
          idx    <= '0;
        end
        ACC: if (cen) begin
          acc <= acc_add;
          idx <= idx + IW'(1);
        end
        SAT: begin
          mixed <= sat_val;
          valid <= 1'b1;
          cnt   <= cnt_nxt;
          peak  <= (cnt_nxt != 8'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jts16_snd_mixseq.sv
// Bench for jts16_snd_mixseq: directed passes with literal expectations plus a
// randomized run checked every cycle against a pass-level behavioural model.
module tb_jts16_snd_mixseq;
  localparam int CH = 4;
  localparam int W  = 16;
  localparam int WO = 16;
  localparam int PH = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cen = 1'b0;
  logic            sample = 1'b0;
  logic [CH*W-1:0] ch_flat = '0;
  logic [CH*8-1:0] gain_flat = '0;
  logic [WO-1:0]   mixed;
  logic            valid, busy, peak, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jts16_snd_mixseq #(.CH(CH), .W(W), .WO(WO), .PEAK_HOLD(PH)) dut (
    .rst_n(rst_n), .clk(clk), .cen(cen), .sample(sample),
    .ch_flat(ch_flat), .gain_flat(gain_flat),
    .mixed(mixed), .valid(valid), .busy(busy), .peak(peak), .overrun(overrun)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // whole-pass result from the arithmetic definition
  function automatic longint model_mix(input logic [CH*W-1:0] c,
                                       input logic [CH*8-1:0] g,
                                       output bit clip);
    longint s, r, maxv, minv;
    s = 0;
    for (int i = 0; i < CH; i++)
      s += longint'($signed(c[i*W +: W])) * longint'(g[i*8 +: 8]);
    r = s >>> 4;
    maxv = (longint'(1) <<< (WO-1)) - 1;
    minv = -(longint'(1) <<< (WO-1));
    clip = 1'b0;
    if (r > maxv) begin r = maxv; clip = 1'b1; end
    else if (r < minv) begin r = minv; clip = 1'b1; end
    return r;
  endfunction

  function automatic logic [CH*W-1:0] pack_ch(input int a, input int b, input int c, input int d);
    logic [CH*W-1:0] v;
    int t[4];
    t[0] = a; t[1] = b; t[2] = c; t[3] = d;
    v = '0;
    for (int i = 0; i < CH; i++) v[i*W +: W] = t[i][W-1:0];
    return v;
  endfunction

  // pass-level model: a pass takes CH enabled cycles then one result cycle
  bit     m_active;
  int     m_left;
  longint m_res;
  bit     m_clip;
  int     m_cnt;
  longint exp_mixed;
  bit     exp_valid, exp_busy, exp_peak, exp_overrun;
  bit     cmp_en = 1'b0;

  task automatic model_reset();
    m_active = 0; m_left = 0; m_res = 0; m_clip = 0; m_cnt = 0;
    exp_mixed = 0; exp_valid = 0; exp_busy = 0; exp_peak = 0; exp_overrun = 0;
  endtask

  task automatic model_step();
    exp_valid = 0;
    if (!m_active) begin
      if (sample) begin
        m_res = model_mix(ch_flat, gain_flat, m_clip);
        m_left = CH;
        m_active = 1;
      end
    end else begin
      if (sample) exp_overrun = 1;
      if (m_left > 0) begin
        if (cen) m_left--;
      end else begin
        exp_mixed = m_res;
        exp_valid = 1;
        if (m_clip) m_cnt = PH;
        else if (m_cnt > 0) m_cnt--;
        m_active = 0;
      end
    end
    exp_busy = m_active;
    exp_peak = (m_cnt != 0);
  endtask

  initial forever begin
    @(posedge clk);
    if (rst_n) model_step();
  end

  // compare process: every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cyc_valid", valid, exp_valid);
      chk("cyc_busy", busy, exp_busy);
      chk("cyc_peak", peak, exp_peak);
      chk("cyc_overrun", overrun, exp_overrun);
      chk("cyc_mixed", longint'($signed(mixed)), exp_mixed);
    end
  end

  task automatic do_pass(input string name, input logic [CH*W-1:0] c, input logic [CH*8-1:0] g,
                         input bit toggle_cen, input bit extra_sample,
                         input longint exp_m, input bit exp_pk, input int exp_lat);
    bit got;
    int lat;
    @(negedge clk);
    ch_flat = c; gain_flat = g; sample = 1'b1; cen = 1'b1;
    got = 0; lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) chk({name, "_busy1"}, busy, 1);
      if (valid) begin
        got = 1; lat = k;
        chk({name, "_mixed"}, longint'($signed(mixed)), exp_m);
        chk({name, "_peak"}, peak, exp_pk);
      end
      sample = extra_sample && (k == 3);
      cen = toggle_cen ? (k % 2 == 0) : 1'b1;
      ch_flat = {$urandom, $urandom};
      gain_flat = $urandom;
    end
    sample = 1'b0;
    cen = 1'b1;
    chk({name, "_done"}, got, 1);
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    logic [CH*W-1:0] base_ch;
    logic [CH*8-1:0] unity;
    bit pin_clip;

    base_ch = pack_ch(1000, 2000, -500, 0);
    unity = {CH{8'h10}};
    model_reset();

    chk("pin_model_base", model_mix(base_ch, unity, pin_clip), 2500);
    chk("pin_model_floor", model_mix(pack_ch(-1001, 0, 0, 0), {CH{8'h08}}, pin_clip), -501);
    chk("pin_model_sat", model_mix(pack_ch(30000, 30000, 0, 0), unity, pin_clip), 32767);
    chk("pin_model_clip", pin_clip, 1);

    repeat (2) @(negedge clk);
    chk("rst_mixed", longint'($signed(mixed)), 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_peak", peak, 0);
    chk("rst_overrun", overrun, 0);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    do_pass("base", base_ch, unity, 0, 0, 2500, 0, 6);
    do_pass("half_pos", pack_ch(1001, 0, 0, 0), {CH{8'h08}}, 0, 0, 500, 0, 6);
    do_pass("half_neg", pack_ch(-1001, 0, 0, 0), {CH{8'h08}}, 0, 0, -501, 0, 6);
    do_pass("clip_pos", pack_ch(30000, 30000, 0, 0), unity, 0, 0, 32767, 1, 6);
    do_pass("clip_neg", pack_ch(-30000, -30000, 0, 0), unity, 0, 0, -32768, 1, 6);
    do_pass("hold1", base_ch, unity, 0, 0, 2500, 1, 6);
    do_pass("hold2", base_ch, unity, 0, 0, 2500, 1, 6);
    do_pass("hold3", base_ch, unity, 0, 0, 2500, 0, 6);
    do_pass("hold4", base_ch, unity, 0, 0, 2500, 0, 6);
    chk("overrun_before", overrun, 0);
    do_pass("cen_toggle", base_ch, unity, 1, 1, 2500, 0, 10);
    chk("overrun_after", overrun, 1);

    // reset in cycle 3 of a pass
    @(negedge clk);
    ch_flat = base_ch; gain_flat = unity; sample = 1'b1; cen = 1'b1;
    @(negedge clk); sample = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_mixed", longint'($signed(mixed)), 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_overrun", overrun, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    do_pass("post_rst", base_ch, unity, 0, 0, 2500, 0, 6);

    // randomized traffic, model checked every cycle
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ch_flat = {$urandom, $urandom};
      if (n % 2 == 0) gain_flat = $urandom;
      else for (int i = 0; i < CH; i++) gain_flat[i*8 +: 8] = 8'($urandom_range(0, 31));
      cen = ($urandom_range(0, 3) != 0);
      sample = ($urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    sample = 1'b0; cen = 1'b1;
    repeat (CH + 4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jts16_snd_mixseq.md
Name: jts16_snd_mixseq

Overview:
- Time-multiplexed N-channel audio mixer for the sound subsystem. It replaces fixed four-input parallel mixing with a single multiply-accumulate unit that walks the channels one per enabled clock.
- Each channel has a 4.4 fixed-point gain. The block saturates the sum and reports clipping with a hold-extended peak flag.
- It sits between the sound sources (FM left/right, PCM after its pole filter, future PSG/extra PCM) and the core's audio output. A sample strobe, usually the FM chip's sample pulse, drives it.

Parameters:
- CH, 4, number of input channels (2..16)
- W, 16, width of each signed channel input; narrower sources are sign-extended by the instantiator
- WO, 16, width of signed mixed output
- PEAK_HOLD, 3, number of mix results for which peak remains asserted after a clipped result, including that result (1..255)

Ports:
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  system clock
- cen  in  1  clock enable for accumulation steps
- sample  in  1  one-clock strobe that requests a new mix pass
- ch_flat  in  CH*W  signed channel samples; channel i occupies bits [i*W +: W]
- gain_flat  in  CH*8  unsigned 4.4 gains; channel i occupies bits [i*8 +: 8]; 8'h10 means unity
- mixed  out  WO  signed saturated mix result
- valid  out  1  one-clock pulse when mixed updates
- busy  out  1  high while a pass is in progress
- peak  out  1  clip indicator with hold
- overrun  out  1  sticky flag: a sample strobe arrived while busy

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; mixed=0, valid=0, busy=0, peak=0, overrun=0; channel index, accumulator and hold counter cleared. A reset mid-pass abandons the pass and produces no valid pulse.
- FSM has three states: IDLE, ACC, SAT.
- IDLE: when sample=1 (not gated by cen):
  - snapshot ch_flat and gain_flat into internal registers;
  - clear the accumulator and set index=0;
  - go to ACC. busy is 1 from the next cycle.
- ACC: on each clock with cen=1:
  - acc += sext(ch[index]) * {1'b0, gain[index]}. The product is W+9 bits signed; the accumulator is W+9+clog2(CH) bits, so it cannot overflow.
  - index increments. After index CH-1 is added, go to SAT.
  - Cycles with cen=0 leave acc and index unchanged.
- SAT: one clock, not gated by cen.
  - r = acc >>> 4 (arithmetic shift, floor toward minus infinity).
  - If r > 2^(WO-1)-1, mixed=2^(WO-1)-1 and clip=1.
  - If r < -2^(WO-1), mixed=-2^(WO-1) and clip=1.
  - Otherwise mixed=r[WO-1:0] and clip=0.
  - valid=1 for exactly one cycle. Go to IDLE; busy=0 from the next cycle.
- Latency with cen held high: sample high in cycle 0 gives busy in cycles 1..CH+1 and valid/new mixed in cycle CH+2. mixed holds its value between passes.
- valid and the IDLE return occur on the same edge. A sample strobe coincident with the valid cycle is accepted, because the state is IDLE in that cycle.
- sample while busy=1: the strobe is ignored, the pass continues unaffected, and overrun is set to 1. overrun clears only on reset.
- Peak hold, on each valid:
  - if clip, cnt=PEAK_HOLD;
  - otherwise, if cnt>0, cnt=cnt-1.
  - peak = (cnt != 0), registered and updated in the same cycle as valid.
- Gains and channel inputs that change during a pass do not affect that pass, because of the snapshot.
- gain 0 contributes zero. A gain of 8'hFF gives about 15.94x.

Test Plan:
- CH=4, W=16, WO=16, all gains 8'h10, ch={1000,2000,-500,0}, cen=1, sample pulse at cycle 0 -> busy cycles 1..5, valid at cycle 6, mixed=2500, peak=0.
- gains 8'h08, single channel 1001, others 0 -> mixed=500. Channel -1001 -> mixed=-501 (floor).
- ch0=ch1=30000 at gain 8'h10 -> mixed=32767, peak=1. ch0=ch1=-30000 -> mixed=-32768, peak=1.
- PEAK_HOLD=3: one clipped pass followed by four non-clipping passes -> peak=1 after the clipped pass and the next 2 passes, 0 from the third non-clipping pass onward.
- cen toggling 1,0,1,0 -> result unchanged, valid at cycle 10 instead of 6. A second sample at cycle 3 -> ignored, overrun=1, mixed equals the first-pass value.
- rst_n low at cycle 3 of a pass -> all outputs 0 immediately, no valid pulse. After rst_n goes high, a new sample completes normally.
